// File: rtl/enemy_spawn_ctrl.sv
// Enemy spawn/respawn controller: level budget, round-robin spawn points, tick-timed spawn delay.
// Optional freeze input enabled by defining ENEMY_FREEZE_EN.
module enemy_spawn_ctrl #(
    parameter int N_ENEMIES        = 4,
    parameter int TOTAL_ENEMIES    = 20,
    parameter int NUM_SPAWN_POINTS = 3,
    parameter int SPAWN_DELAY      = 3
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        one_sec_clk_i,
    input  logic                        start_i,
    input  logic [N_ENEMIES-1:0]        enemy_die_i,
    input  logic [NUM_SPAWN_POINTS-1:0] spawn_busy_i,
`ifdef ENEMY_FREEZE_EN
    input  logic                        freeze_i,
`endif
    output logic [N_ENEMIES-1:0]        enemy_revive_o,
    output logic [N_ENEMIES-1:0]        enemy_alive_o,
    output logic [1:0]                  spawn_point_o,
    output logic [5:0]                  enemy_left_o,
    output logic                        level_clear_o
);

    typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

    state_t               state_q, state_d;
    logic [N_ENEMIES-1:0] alive_q, alive_d, revive_q, revive_d, pick;
    logic [1:0]           sp_q, sp_d, rr_q, rr_d, rr_inc;
    logic [5:0]           left_q, left_d, to_spawn_q, to_spawn_d, cnt;
    logic [3:0]           delay_q, delay_d, busy_ext;
    logic                 sec_q, tick, freeze;

`ifdef ENEMY_FREEZE_EN
    assign freeze = freeze_i;
`else
    assign freeze = 1'b0;
`endif

    assign tick           = one_sec_clk_i & ~sec_q;
    assign enemy_revive_o = revive_q;
    assign enemy_alive_o  = alive_q;
    assign spawn_point_o  = sp_q;
    assign enemy_left_o   = left_q;
    assign level_clear_o  = (state_q == CLEAR);
    assign rr_inc         = (rr_q == 2'(NUM_SPAWN_POINTS - 1)) ? 2'd0 : rr_q + 2'd1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            alive_q    <= '0;
            revive_q   <= '0;
            sp_q       <= '0;
            rr_q       <= '0;
            left_q     <= '0;
            to_spawn_q <= '0;
            delay_q    <= '0;
            sec_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            alive_q    <= alive_d;
            revive_q   <= revive_d;
            sp_q       <= sp_d;
            rr_q       <= rr_d;
            left_q     <= left_d;
            to_spawn_q <= to_spawn_d;
            delay_q    <= delay_d;
            sec_q      <= one_sec_clk_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        alive_d    = alive_q;
        revive_d   = '0;
        sp_d       = sp_q;
        rr_d       = rr_q;
        to_spawn_d = to_spawn_q;
        delay_d    = delay_q;

        busy_ext = '0;
        busy_ext[NUM_SPAWN_POINTS-1:0] = spawn_busy_i;

        // lowest-index dead channel, one-hot; zero when all are alive
        pick = '0;
        for (int i = N_ENEMIES - 1; i >= 0; i--) begin
            if (!alive_q[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end

        if (start_i) begin
            state_d    = RUN;
            alive_d    = '0;
            rr_d       = '0;
            delay_d    = '0;
            to_spawn_d = 6'(TOTAL_ENEMIES);
        end else if (state_q == RUN) begin
            // dying channels are alive, spawn candidates are dead: the two never overlap
            alive_d = alive_q & ~enemy_die_i;
            if (delay_q == 4'd0 && to_spawn_q != 6'd0 && pick != '0 && !freeze) begin
                rr_d = rr_inc;
                if (!busy_ext[rr_q]) begin
                    revive_d   = pick;
                    alive_d    = alive_d | pick;
                    sp_d       = rr_q;
                    to_spawn_d = to_spawn_q - 6'd1;
                    delay_d    = 4'(SPAWN_DELAY);
                end
            end else if (tick && delay_q != 4'd0 && !freeze) begin
                delay_d = delay_q - 4'd1;
            end
            if (to_spawn_q == 6'd0 && alive_q == '0)
                state_d = CLEAR;
        end

        cnt = '0;
        for (int i = 0; i < N_ENEMIES; i++)
            cnt = cnt + 6'(alive_d[i]);
        left_d = to_spawn_d + cnt;
    end

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// Directed self-checking bench for enemy_spawn_ctrl (default build plus optional freeze scenario).
module tb_enemy_spawn_ctrl;

    logic       clk = 1'b0, reset = 1'b1, one_sec = 1'b0, freeze = 1'b0;
    logic       start = 1'b0, start2 = 1'b0;
    logic [3:0] die = '0, die2 = '0;
    logic [2:0] busy = '0;
    logic [3:0] revive, alive, revive2, alive2;
    logic [1:0] sp, sp2;
    logic [5:0] left, left2;
    logic       clr, clr2;
    int         asserts = 0, fails = 0;

    always #5 clk = ~clk;

    enemy_spawn_ctrl u1 (
        .clk_i(clk), .reset_i(reset), .one_sec_clk_i(one_sec), .start_i(start),
        .enemy_die_i(die), .spawn_busy_i(busy),
`ifdef ENEMY_FREEZE_EN
        .freeze_i(freeze),
`endif
        .enemy_revive_o(revive), .enemy_alive_o(alive), .spawn_point_o(sp),
        .enemy_left_o(left), .level_clear_o(clr));

    enemy_spawn_ctrl #(.TOTAL_ENEMIES(2)) u2 (
        .clk_i(clk), .reset_i(reset), .one_sec_clk_i(one_sec), .start_i(start2),
        .enemy_die_i(die2), .spawn_busy_i(busy),
`ifdef ENEMY_FREEZE_EN
        .freeze_i(freeze),
`endif
        .enemy_revive_o(revive2), .enemy_alive_o(alive2), .spawn_point_o(sp2),
        .enemy_left_o(left2), .level_clear_o(clr2));

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic tick();
        one_sec = 1'b1; step();
        one_sec = 1'b0; step();
    endtask

    task automatic test_reset();
        #2;
        asserts++;
        if ({revive, alive, sp, left, clr} !== 15'd0) begin
            fails++; $display("FAIL reset_outputs got %h want 0", {revive, alive, sp, left, clr});
        end
        step(); reset = 1'b0; step();
        asserts++;
        if (left !== 6'd0 || revive !== 4'd0) begin
            fails++; $display("FAIL idle_hold left=%0d revive=%b want 0/0", left, revive);
        end
    endtask

    task automatic test_first_spawns();
        start = 1'b1; step(); start = 1'b0;
        asserts++;
        if (left !== 6'd20 || revive !== 4'd0) begin
            fails++; $display("FAIL start_load left=%0d revive=%b want 20/0000", left, revive);
        end
        step();
        asserts++;
        if (revive !== 4'b0001 || sp !== 2'd0 || alive !== 4'b0001 || left !== 6'd20) begin
            fails++; $display("FAIL spawn0 revive=%b sp=%0d alive=%b left=%0d want 0001/0/0001/20",
                              revive, sp, alive, left);
        end
        for (int k = 1; k < 4; k++) begin
            tick(); tick();
            asserts++;
            if (revive !== 4'd0) begin
                fails++; $display("FAIL early_spawn%0d revive=%b want 0000", k, revive);
            end
            tick();
            asserts++;
            if (revive !== 4'(1 << k) || sp !== 2'(k % 3)) begin
                fails++; $display("FAIL spawn%0d revive=%b sp=%0d want %b/%0d",
                                  k, revive, sp, 4'(1 << k), k % 3);
            end
        end
        asserts++;
        if (alive !== 4'b1111 || left !== 6'd20) begin
            fails++; $display("FAIL all_alive alive=%b left=%0d want 1111/20", alive, left);
        end
    endtask

    task automatic test_death_respawn();
        die = 4'b0100; step(); die = '0;
        asserts++;
        if (left !== 6'd19 || alive !== 4'b1011) begin
            fails++; $display("FAIL die_ch2 left=%0d alive=%b want 19/1011", left, alive);
        end
        tick(); tick(); tick();
        asserts++;
        if (revive !== 4'b0100 || sp !== 2'd1 || left !== 6'd19) begin
            fails++; $display("FAIL respawn_ch2 revive=%b sp=%0d left=%0d want 0100/1/19", revive, sp, left);
        end
    endtask

    task automatic test_busy();
        die = 4'b0001; step(); die = '0;
        asserts++;
        if (left !== 6'd18) begin
            fails++; $display("FAIL die_ch0 left=%0d want 18", left);
        end
        busy = 3'b101;
        tick(); tick(); tick();
        asserts++;
        if (revive !== 4'd0) begin
            fails++; $display("FAIL busy_skip2 revive=%b want 0000", revive);
        end
        step();
        asserts++;
        if (revive !== 4'd0) begin
            fails++; $display("FAIL busy_skip0 revive=%b want 0000", revive);
        end
        step();
        asserts++;
        if (revive !== 4'b0001 || sp !== 2'd1) begin
            fails++; $display("FAIL busy_spawn revive=%b sp=%0d want 0001/1", revive, sp);
        end
        busy = '0;
    endtask

    task automatic test_multi_death();
        die = 4'b0101; step(); die = '0;
        asserts++;
        if (left !== 6'd16 || alive !== 4'b1010) begin
            fails++; $display("FAIL double_die left=%0d alive=%b want 16/1010", left, alive);
        end
        die = 4'b0101; step(); die = '0;
        asserts++;
        if (left !== 6'd16) begin
            fails++; $display("FAIL dead_die left=%0d want 16", left);
        end
        die = 4'b0110; step(); die = '0;
        asserts++;
        if (left !== 6'd15 || alive !== 4'b1000) begin
            fails++; $display("FAIL mixed_die left=%0d alive=%b want 15/1000", left, alive);
        end
    endtask

    task automatic test_spawn_and_death();
        tick(); tick();
        one_sec = 1'b1; step();
        one_sec = 1'b0; die = 4'b1000; step(); die = '0;
        asserts++;
        if (revive !== 4'b0001 || alive !== 4'b0001 || left !== 6'd14) begin
            fails++; $display("FAIL spawn_die revive=%b alive=%b left=%0d want 0001/0001/14",
                              revive, alive, left);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; #2;
        asserts++;
        if ({revive, alive, sp, left, clr} !== 15'd0) begin
            fails++; $display("FAIL async_reset got %h want 0", {revive, alive, sp, left, clr});
        end
        step(); reset = 1'b0;
        tick(); tick(); tick(); tick();
        asserts++;
        if (alive !== 4'd0 || revive !== 4'd0 || left !== 6'd0) begin
            fails++; $display("FAIL post_reset alive=%b revive=%b left=%0d want 0", alive, revive, left);
        end
    endtask

`ifdef ENEMY_FREEZE_EN
    task automatic test_freeze();
        start = 1'b1; step(); start = 1'b0; step();
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        asserts++;
        if (alive !== 4'b0001 || revive !== 4'd0) begin
            fails++; $display("FAIL freeze_hold alive=%b revive=%b want 0001/0000", alive, revive);
        end
        freeze = 1'b0;
        tick(); tick();
        asserts++;
        if (revive !== 4'd0) begin
            fails++; $display("FAIL freeze_delay revive=%b want 0000", revive);
        end
        tick();
        asserts++;
        if (revive !== 4'b0010) begin
            fails++; $display("FAIL unfreeze_spawn revive=%b want 0010", revive);
        end
    endtask
`endif

    task automatic test_level_clear();
        start2 = 1'b1; step(); start2 = 1'b0;
        asserts++;
        if (left2 !== 6'd2) begin
            fails++; $display("FAIL l2_start left=%0d want 2", left2);
        end
        step();
        tick(); tick(); tick();
        asserts++;
        if (revive2 !== 4'b0010 || sp2 !== 2'd1 || alive2 !== 4'b0011) begin
            fails++; $display("FAIL l2_spawn revive=%b sp=%0d alive=%b want 0010/1/0011", revive2, sp2, alive2);
        end
        die2 = 4'b0011; step(); die2 = '0;
        asserts++;
        if (left2 !== 6'd0 || clr2 !== 1'b0) begin
            fails++; $display("FAIL l2_kill left=%0d clr=%b want 0/0", left2, clr2);
        end
        step(); step();
        asserts++;
        if (clr2 !== 1'b1 || revive2 !== 4'd0) begin
            fails++; $display("FAIL l2_clear clr=%b revive=%b want 1/0000", clr2, revive2);
        end
        start2 = 1'b1; step(); start2 = 1'b0;
        asserts++;
        if (clr2 !== 1'b0 || left2 !== 6'd2) begin
            fails++; $display("FAIL l2_restart clr=%b left=%0d want 0/2", clr2, left2);
        end
    endtask

    initial begin
        test_reset();
        test_first_spawns();
        test_death_respawn();
        test_busy();
        test_multi_death();
        test_spawn_and_death();
        test_reset_mid();
`ifdef ENEMY_FREEZE_EN
        test_freeze();
`endif
        test_level_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/enemy_spawn_ctrl.md
Name: enemy_spawn_ctrl

Overview:
- Parametrised controller that spawns, tracks and respawns N enemy tanks for one level.
- Sits between the bullet collision logic, which reports enemy deaths, and the per-channel tank_bot instances, which consume the revive pulses and spawn-point indices.
- Generalises the current single-enemy, fixed-lives scheme:
  - N_ENEMIES channels.
  - A level-wide enemy budget.
  - Round-robin spawn points with busy check.
  - A spawn delay timed in one-second ticks.

Parameters:
N_ENEMIES, 4, number of enemy tank channels (1..8)
TOTAL_ENEMIES, 20, enemies to destroy per level (1..63)
NUM_SPAWN_POINTS, 3, spawn locations selected round-robin (1..4)
SPAWN_DELAY, 3, one_sec ticks between consecutive spawns (0..15)

Ports:
clk_i  input  1  VGA clock
reset_i  input  1  asynchronous active-high reset
one_sec_clk_i  input  1  one-second timing signal; its rising edge is detected synchronously inside the block
start_i  input  1  single-cycle pulse: begin or restart the level
enemy_die_i  input  N_ENEMIES  single-cycle death pulse per channel
spawn_busy_i  input  NUM_SPAWN_POINTS  spawn point occupied by a tank box
enemy_revive_o  output  N_ENEMIES  single-cycle revive pulse per channel
enemy_alive_o  output  N_ENEMIES  channel currently alive
spawn_point_o  output  2  spawn point index for the current revive, valid with the pulse
enemy_left_o  output  6  enemies not yet destroyed (unspawned + alive)
level_clear_o  output  1  level finished, level-held

Behaviour:
- Reset (asynchronous, active-high), all outputs and state cleared:
  - state=IDLE.
  - enemy_revive_o=0, enemy_alive_o=0, spawn_point_o=0, enemy_left_o=0, level_clear_o=0.
  - Round-robin pointer rr=0; to_spawn=0; delay=0; tick-edge register=0.
- tick: one-cycle internal strobe on a 0->1 transition of one_sec_clk_i, derived from a registered previous value.
- States: IDLE, RUN, CLEAR.
- IDLE: waits for start_i. On start_i:
  - to_spawn=TOTAL_ENEMIES, delay=0, rr=0, alive=0.
  - Next state RUN.
- RUN, spawn condition (all must hold):
  - delay==0.
  - to_spawn>0.
  - At least one channel dead.
  - Freeze not active.
- RUN, spawn action when the condition holds:
  - If spawn_busy_i[rr]=0: next cycle the lowest-index dead channel k gets enemy_revive_o[k]=1 for exactly one cycle and spawn_point_o=rr. enemy_alive_o[k] rises in that same cycle. to_spawn decrements, delay reloads to SPAWN_DELAY, and rr advances.
  - If spawn_busy_i[rr]=1: rr advances and nothing spawns; the next point is tried the following cycle.
- rr wraps from NUM_SPAWN_POINTS-1 to 0.
- delay decrements by 1 on each tick while RUN and delay>0. It saturates at 0.
- Deaths:
  - enemy_die_i[k] with alive[k]=1 clears alive[k].
  - A death on a dead channel is ignored.
  - Multiple deaths in one cycle are all honoured.
- enemy_left_o = to_spawn + popcount(alive). It is registered and updates one cycle after the causing event.
- RUN->CLEAR when to_spawn==0 and alive==0. level_clear_o=1 in CLEAR.
- CLEAR->RUN on start_i, with the same reload as from IDLE. level_clear_o drops in the same cycle.
- start_i during RUN restarts the level. Any revive scheduled that cycle is cancelled.
- A spawn and a death on different channels in the same cycle are both honoured. A channel is never revived in the same cycle its death is registered.
- reset_i mid-level aborts to IDLE immediately; no pending pulse is emitted.

Optional Feature:
ENEMY_FREEZE_EN
- Defined:
  - Adds input freeze_i (1 bit).
  - While freeze_i=1, delay does not decrement and no spawn occurs.
  - Deaths, enemy_left_o and rr stay live.
- Undefined:
  - Port absent; freeze is treated as 0.

Test Plan:
1. Reset, then start_i with SPAWN_DELAY=3, no busy -> revives on ch0, ch1, ch2, ch3 spaced 3 ticks apart; spawn_point_o sequence 0,1,2,0; enemy_left_o=20.
2. All 4 channels alive, die ch2 -> enemy_left_o 20->19; next spawn after delay revives ch2 (lowest dead).
3. spawn_busy_i=3'b001 at spawn time -> no revive that cycle; rr moves to 1; revive follows with spawn_point_o=1.
4. TOTAL_ENEMIES=2, kill both after spawn -> enemy_left_o reaches 0; level_clear_o=1 held; start_i -> level_clear_o=0, enemy_left_o=2.
5. Same-cycle enemy_die_i=4'b0101 with ch0 and ch2 alive -> enemy_left_o drops by 2 in one update; deaths on dead channels leave the count unchanged.
6. reset_i asserted mid-delay -> all outputs 0 asynchronously; no revive after release until start_i. With ENEMY_FREEZE_EN, freeze_i=1 for 5 ticks -> no revive and delay held.
